// File: rtl/itch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : itch_pkg
// Purpose  : Shared MoldUDP64 / ITCH framing constants and FSM state type.
// Revision : 1.0  initial release
// ============================================================================
package itch_pkg;

  localparam int          MOLD_HDR_BYTES = 20;
  localparam logic [15:0] MOLD_HEARTBEAT = 16'h0000;
  localparam logic [15:0] MOLD_EOS       = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    LEN_HI  = 3'd2,
    LEN_LO  = 3'd3,
    PAYLOAD = 3'd4,
    SKIP    = 3'd5,
    DRAIN   = 3'd6
  } mold_state_t;

endpackage
`default_nettype wire

// File: rtl/moldudp64_framer.sv
`default_nettype none
// ============================================================================
// Module   : moldudp64_framer
// Purpose  : Strips MoldUDP64 framing from a UDP payload byte stream and
//            presents one ITCH message at a time, tagged with its sequence
//            number. Framing faults pulse frame_err and never reach the
//            parser as a valid message.
// Revision : 1.0  initial release
// ============================================================================
module moldudp64_framer
  import itch_pkg::*;
#(
  parameter int MAX_MSG_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pkt_data,
  input  logic        pkt_valid,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  output logic        start_msg,
  output logic        end_msg,
  output logic [7:0]  message,
  output logic        valid,
  output logic [79:0] session,
  output logic [63:0] seq_num,
  output logic        frame_err,
  output logic        pkt_done
);

  mold_state_t state_q, state_d;
  logic [4:0]  hdr_cnt_q, hdr_cnt_d;
  logic [71:0] hdr_sh_q, hdr_sh_d;     // last nine header bytes, newest in [7:0]
  logic [79:0] session_q, session_d;
  logic [63:0] seq_q, seq_d;
  logic        inc_q, inc_d;           // deferred increment keeps seq stable through end_msg
  logic [15:0] rem_q, rem_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        drain_ok_q, drain_ok_d;  // draining after heartbeat/EOS is not an error
  logic        drain_err_q, drain_err_d;
  logic        start_q, start_d, end_q, end_d, valid_q, valid_d;
  logic [7:0]  msg_q, msg_d;
  logic        err_q, err_d, done_q, done_d;

  logic [15:0] len_w, cnt_w, rem_dec_w;
  logic        last_w, fin_w;
  mold_state_t st_w;
  logic [4:0]  hcnt_w;

  assign len_w     = {len_hi_q, pkt_data};
  assign cnt_w     = {hdr_sh_q[7:0], pkt_data};
  assign rem_dec_w = rem_q - 16'd1;
  assign last_w    = ((bcnt_q + 16'd1) == len_q);

  // Next-state, counter and output-byte decode for one input byte per cycle.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_sh_d    = hdr_sh_q;
    session_d   = session_q;
    seq_d       = seq_q + {63'd0, inc_q};
    inc_d       = 1'b0;
    rem_d       = rem_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    bcnt_d      = bcnt_q;
    drain_ok_d  = drain_ok_q;
    drain_err_d = drain_err_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    valid_d     = 1'b0;
    msg_d       = 8'h00;
    err_d       = 1'b0;
    done_d      = 1'b0;
    fin_w       = 1'b0;
    st_w        = state_q;
    hcnt_w      = hdr_cnt_q;

    // A start-of-packet always begins a fresh header; an interrupted message
    // gets a terminator cycle so the parser discards it.
    if (pkt_valid && pkt_sop) begin
      if (state_q == PAYLOAD) begin
        end_d = 1'b1;
        err_d = 1'b1;
      end
      st_w   = HDR;
      hcnt_w = 5'd0;
    end

    if (pkt_valid) begin
      case (st_w)
        HDR: begin
          state_d   = HDR;
          hdr_sh_d  = {hdr_sh_q[63:0], pkt_data};
          hdr_cnt_d = hcnt_w + 5'd1;
          if (hcnt_w == 5'd9)  session_d = {hdr_sh_q[71:0], pkt_data};
          if (hcnt_w == 5'd17) seq_d     = {hdr_sh_q[55:0], pkt_data};
          if (hcnt_w == 5'(MOLD_HDR_BYTES - 1)) begin
            if (cnt_w == MOLD_HEARTBEAT || cnt_w == MOLD_EOS) begin
              if (pkt_eop) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d     = DRAIN;
                drain_ok_d  = 1'b1;
                drain_err_d = 1'b0;
              end
            end else if (pkt_eop) begin
              done_d  = 1'b1;
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              rem_d   = cnt_w;
              state_d = LEN_HI;
            end
          end else if (pkt_eop) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        LEN_HI: begin
          len_hi_d = pkt_data;
          if (pkt_eop) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LEN_LO;
          end
        end
        LEN_LO: begin
          len_d  = len_w;
          bcnt_d = 16'd0;
          if (len_w == 16'd0) begin
            fin_w = 1'b1;
          end else begin
            if (len_w > 16'(MAX_MSG_LEN)) begin
              err_d   = 1'b1;
              state_d = SKIP;
            end else begin
              state_d = PAYLOAD;
            end
            if (pkt_eop) begin
              done_d  = 1'b1;
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PAYLOAD: begin
          msg_d  = pkt_data;
          bcnt_d = bcnt_q + 16'd1;
          if (last_w) begin
            start_d = (bcnt_q == 16'd0);
            end_d   = 1'b1;
            valid_d = 1'b1;
            fin_w   = 1'b1;
          end else if (pkt_eop) begin
            end_d   = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            start_d = (bcnt_q == 16'd0);
            valid_d = 1'b1;
          end
        end
        SKIP: begin
          bcnt_d = bcnt_q + 16'd1;
          if (last_w) begin
            fin_w = 1'b1;
          end else if (pkt_eop) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (!drain_ok_q && !drain_err_q) begin
            err_d       = 1'b1;
            drain_err_d = 1'b1;
          end
          if (pkt_eop) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Common bookkeeping once a message block (emitted, empty or skipped) ends.
    if (fin_w) begin
      inc_d = 1'b1;
      rem_d = rem_dec_w;
      if (rem_dec_w == 16'd0) begin
        if (pkt_eop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d     = DRAIN;
          drain_ok_d  = 1'b0;
          drain_err_d = 1'b0;
        end
      end else if (pkt_eop) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = LEN_HI;
      end
    end
  end

  // State, counters and registered outputs; asynchronous reset to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= 5'd0;
      hdr_sh_q    <= 72'd0;
      session_q   <= 80'd0;
      seq_q       <= 64'd0;
      inc_q       <= 1'b0;
      rem_q       <= 16'd0;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      bcnt_q      <= 16'd0;
      drain_ok_q  <= 1'b0;
      drain_err_q <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      valid_q     <= 1'b0;
      msg_q       <= 8'd0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_sh_q    <= hdr_sh_d;
      session_q   <= session_d;
      seq_q       <= seq_d;
      inc_q       <= inc_d;
      rem_q       <= rem_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      drain_ok_q  <= drain_ok_d;
      drain_err_q <= drain_err_d;
      start_q     <= start_d;
      end_q       <= end_d;
      valid_q     <= valid_d;
      msg_q       <= msg_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign start_msg = start_q;
  assign end_msg   = end_q;
  assign message   = msg_q;
  assign valid     = valid_q;
  assign session   = session_q;
  assign seq_num   = seq_q;
  assign frame_err = err_q;
  assign pkt_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_moldudp64_framer
// Purpose  : Directed self-checking bench for moldudp64_framer. Expected
//            output bytes are queued as packets are built and popped as the
//            framer emits them.
// Revision : 1.0  initial release
// ============================================================================
module tb_moldudp64_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pkt_data = 8'h00;
  logic        pkt_valid = 1'b0;
  logic        pkt_sop = 1'b0;
  logic        pkt_eop = 1'b0;
  logic        start_msg, end_msg, valid, frame_err, pkt_done;
  logic [7:0]  message;
  logic [79:0] session;
  logic [63:0] seq_num;

  moldudp64_framer #(.MAX_MSG_LEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_sop   (pkt_sop),
    .pkt_eop   (pkt_eop),
    .start_msg (start_msg),
    .end_msg   (end_msg),
    .message   (message),
    .valid     (valid),
    .session   (session),
    .seq_num   (seq_num),
    .frame_err (frame_err),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic        e;
    logic        v;
    logic [7:0]  d;
    logic [63:0] q;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] pq[$];
  logic [74:0] mon_obs, mon_want;
  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_done = 0;
  int e0, d0;

  // Output monitor: counts pulses and scores every emitted byte/terminator.
  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (pkt_done)  n_done++;
    if (!rst && (valid || start_msg || end_msg)) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed s=%0b e=%0b v=%0b d=%02h seq=%0h required none",
               start_msg, end_msg, valid, message, seq_num);
      end
      if (exp_q.size() != 0) begin
        mon_e    = exp_q.pop_front();
        mon_obs  = {start_msg, end_msg, valid, (valid ? message : 8'h00), seq_num};
        mon_want = {mon_e.s, mon_e.e, mon_e.v, (mon_e.v ? mon_e.d : 8'h00), mon_e.q};
        assert (mon_obs === mon_want) else begin
          errors++;
          $error("FAIL out_byte observed=%0h required=%0h", mon_obs, mon_want);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, want);
    end
  endtask

  task automatic tick_idle(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_valid = 1'b0;
      pkt_sop   = 1'b0;
      pkt_eop   = 1'b0;
      pkt_data  = 8'h00;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input logic sop, input logic eop);
    for (int i = lo; i <= hi; i++) begin
      pkt_data  = pq[i];
      pkt_valid = 1'b1;
      pkt_sop   = sop && (i == lo);
      pkt_eop   = eop && (i == hi);
      @(posedge clk);
      #2;
    end
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
  endtask

  task automatic pq_hdr(input logic [79:0] sess, input logic [63:0] sq, input logic [15:0] cnt);
    pq.delete();
    for (int i = 0; i < 10; i++) pq.push_back(sess[79-8*i -: 8]);
    for (int i = 0; i < 8; i++)  pq.push_back(sq[63-8*i -: 8]);
    pq.push_back(cnt[15:8]);
    pq.push_back(cnt[7:0]);
  endtask

  task automatic pq_msg(input logic [15:0] len, input logic [7:0] c0, input logic [63:0] sq,
                        input logic expect_out);
    exp_t x;
    logic [7:0] b;
    pq.push_back(len[15:8]);
    pq.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'(c0 + i);
      pq.push_back(b);
      if (expect_out) begin
        x = '{s: (i == 0), e: (i == int'(len) - 1), v: 1'b1, d: b, q: sq};
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic push_exp(input logic s, input logic e, input logic v, input logic [7:0] d,
                          input logic [63:0] q);
    exp_t x;
    x = '{s: s, e: e, v: v, d: d, q: q};
    exp_q.push_back(x);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #2;
    chk("rst_flags",   {start_msg, end_msg, valid, frame_err, pkt_done}, 0);
    chk("rst_message", message, 0);
    chk("rst_session", session, 0);
    chk("rst_seq",     seq_num, 0);
    rst = 1'b0;
    tick_idle(2);

    // Two good messages
    e0 = n_err; d0 = n_done;
    pq_hdr("TESTSESS01", 64'd100, 16'd2);
    pq_msg(16'd36, "A", 64'd100, 1'b1);
    pq_msg(16'd23, "D", 64'd101, 1'b1);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_session", session, "TESTSESS01");
    chk("t1_err",     n_err - e0, 0);
    chk("t1_done",    n_done - d0, 1);

    // Heartbeat
    e0 = n_err; d0 = n_done;
    pq_hdr("HEARTBEAT2", 64'd55, 16'h0000);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("hb_session", session, "HEARTBEAT2");
    chk("hb_err",     n_err - e0, 0);
    chk("hb_done",    n_done - d0, 1);

    // Early eop on payload byte 20 of a 36-byte message
    e0 = n_err; d0 = n_done;
    pq_hdr("TRUNCATE03", 64'd300, 16'd1);
    pq_msg(16'd36, 8'h30, 64'd300, 1'b0);
    for (int i = 0; i < 19; i++) push_exp((i == 0), 1'b0, 1'b1, 8'(8'h30 + i), 64'd300);
    push_exp(1'b0, 1'b1, 1'b0, 8'h43, 64'd300);
    send_range(0, 41, 1'b1, 1'b1);
    tick_idle(4);
    chk("trunc_drained", exp_q.size(), 0);
    chk("trunc_err",     n_err - e0, 1);
    chk("trunc_done",    n_done - d0, 1);

    // Lengths 0, 65 (oversize), 1
    e0 = n_err; d0 = n_done;
    pq_hdr("SKIPTEST04", 64'd1000, 16'd3);
    pq_msg(16'd0,  8'h00, 64'd0, 1'b0);
    pq_msg(16'd65, 8'h10, 64'd0, 1'b0);
    pq_msg(16'd1,  8'h7E, 64'd1002, 1'b1);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("skip_drained", exp_q.size(), 0);
    chk("skip_err",     n_err - e0, 1);
    chk("skip_done",    n_done - d0, 1);

    // Sequence number wrap
    e0 = n_err; d0 = n_done;
    pq_hdr("WRAPTEST05", 64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
    pq_msg(16'd3, 8'h41, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    pq_msg(16'd2, 8'h61, 64'd0, 1'b1);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_seq_after", seq_num, 1);
    chk("wrap_err",     n_err - e0, 0);
    chk("wrap_done",    n_done - d0, 1);

    // New sop at payload byte 5 aborts the message and restarts the header
    e0 = n_err;
    pq_hdr("ABORTED_06", 64'd200, 16'd1);
    pq_msg(16'd10, 8'h50, 64'd200, 1'b0);
    for (int i = 0; i < 4; i++) push_exp((i == 0), 1'b0, 1'b1, 8'(8'h50 + i), 64'd200);
    push_exp(1'b0, 1'b1, 1'b0, 8'h00, 64'd200);
    send_range(0, 25, 1'b1, 1'b0);
    pq_hdr("RESTART_07", 64'd500, 16'd1);
    pq_msg(16'd2, 8'h90, 64'd500, 1'b1);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("abort_drained", exp_q.size(), 0);
    chk("abort_err",     n_err - e0, 1);
    chk("abort_session", session, "RESTART_07");

    // Reset mid-payload; trailing bytes ignored, next packet parsed
    pq_hdr("RESETME_08", 64'd700, 16'd1);
    pq_msg(16'd10, 8'hA0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) push_exp((i == 0), 1'b0, 1'b1, 8'(8'hA0 + i), 64'd700);
    send_range(0, 24, 1'b1, 1'b0);
    tick_idle(1);
    rst = 1'b1;
    #2;
    chk("midrst_flags", {start_msg, end_msg, valid, frame_err, pkt_done}, 0);
    chk("midrst_data",  {message, session, seq_num}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    e0 = n_err; d0 = n_done;
    send_range(25, 31, 1'b0, 1'b1);
    tick_idle(3);
    pq_hdr("AFTERRST09", 64'd9, 16'd1);
    pq_msg(16'd1, 8'h5A, 64'd9, 1'b1);
    send_range(0, pq.size() - 1, 1'b1, 1'b1);
    tick_idle(4);
    chk("postrst_drained", exp_q.size(), 0);
    chk("postrst_err",     n_err - e0, 0);
    chk("postrst_done",    n_done - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moldudp64_framer.md
# moldudp64_framer

Strips MoldUDP64 framing from the UDP payload byte stream and emits one ITCH message at a time on the `start_msg`/`end_msg`/`message`/`valid` byte interface that the ITCH field parser consumes. It sits directly upstream of that parser. It parses the 20-byte packet header, walks the 2-byte length-prefixed message blocks, and tags each message with its MoldUDP64 sequence number. Malformed framing is reported on `frame_err` and is never presented to the parser as a valid message.

## Interface
- `MAX_MSG_LEN`, 64: largest accepted message block length in bytes; longer blocks are skipped.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pkt_data` in 8: UDP payload byte.
- `pkt_valid` in 1: `pkt_data` valid this cycle.
- `pkt_sop` in 1: first byte of packet; qualified by `pkt_valid`.
- `pkt_eop` in 1: last byte of packet; qualified by `pkt_valid`.
- `start_msg` out 1: first byte of an ITCH message.
- `end_msg` out 1: last byte of an ITCH message.
- `message` out 8: ITCH message byte.
- `valid` out 1: `message` byte valid.
- `session` out 80: session ID of the current packet, latched after header byte 9.
- `seq_num` out 64: sequence number of the current message; stable from `start_msg` through `end_msg`.
- `frame_err` out 1: one-cycle pulse on any framing error.
- `pkt_done` out 1: one-cycle pulse when a packet has been fully consumed, whether good or errored.

## Operation
- FSM states: IDLE, HDR, LEN_HI, LEN_LO, PAYLOAD, SKIP, DRAIN.
- IDLE:
  - `pkt_valid && pkt_sop` → HDR; that byte is header byte 0.
  - Bytes without sop are ignored.
- HDR: collects bytes 0–19, big-endian.
  - 0–9: session.
  - 10–17: base sequence number.
  - 18–19: `msg_count`.
  - After byte 19:
    - `msg_count` is 0 (heartbeat) or 0xFFFF (end of session) → DRAIN.
    - Otherwise → LEN_HI with `remaining = msg_count`.
- LEN_HI / LEN_LO: assemble the 16-bit block length `len`, big-endian.
  - `len == 0`: counts as a message, `seq_num` increments, nothing is emitted; stay in LEN_HI.
  - `len > MAX_MSG_LEN`: pulse `frame_err`, go to SKIP for `len` bytes. The message still counts and `seq_num` still increments.
  - Otherwise → PAYLOAD.
- PAYLOAD: forward each input byte with `valid=1`.
  - First byte: `start_msg=1`.
  - Byte number `len`: `end_msg=1`.
  - A single-byte message asserts both flags on the same byte.
- After the last byte of a message, `remaining` decrements and `seq_num` increments by 1, wrapping modulo 2^64.
  - `remaining == 0` → DRAIN.
  - Otherwise → LEN_HI.
- DRAIN: discards bytes until `pkt_eop`.
  - Any byte discarded here other than after heartbeat/EOS pulses `frame_err` once.
- `pkt_eop` on the byte that finishes the expected structure → `pkt_done`, IDLE.
- Early `pkt_eop` (in HDR, LEN_*, PAYLOAD or SKIP, or with `remaining > 0`): `pkt_done` and `frame_err`, → IDLE.
  - In PAYLOAD the eop byte is emitted with `end_msg=1, valid=0`, so the parser never raises `valid_msg`.
- `pkt_valid` gap inside PAYLOAD: output `valid=0` that cycle with `start_msg=end_msg=0`. The parser flags the message invalid; the framer takes no other action.
- `pkt_sop` in any non-IDLE state: abort the current packet.
  - In PAYLOAD, emit one terminator cycle with `end_msg=1, valid=0`, and pulse `frame_err`.
  - Restart HDR with the new byte as header byte 0.
  - The terminator and the new header byte occur in the same cycle; headers produce no output, so there is no conflict.

## Timing
- Every output is registered; latency from payload input byte to output byte is 1 cycle.
- Outputs are not backpressured; one input byte is handled per cycle.
- `seq_num` updates in the cycle after `end_msg`. A `start_msg` immediately following (minimum 2-cycle length gap) already sees the new value.
- Reset value of all outputs is 0. FSM resets to IDLE; all counters reset to 0.
- `rst` mid-packet: the remainder of that packet is ignored until the next `pkt_sop`.
- `frame_err` and `pkt_done` are single-cycle pulses. They may coincide on the same cycle.

## Structure
- Shared package `itch_pkg`:
  - `MOLD_HDR_BYTES = 20`.
  - `MOLD_HEARTBEAT = 16'h0000`.
  - `MOLD_EOS = 16'hFFFF`.
  - Enum `mold_state_t` for the FSM states.
- Single module; no sub-module is needed.

## Test plan
- Header with session "TESTSESS01", seq 100, count 2, followed by blocks [len 36 'A'…] and [len 23 'D'…] → two framed messages, `seq_num` 100 then 101, `pkt_done` once, no `frame_err`.
- Count 0 heartbeat, 20-byte packet → no output, `pkt_done`, `session` updated, no `frame_err`.
- Count 1, len 36, `pkt_eop` on payload byte 20 → byte 20 output with `end_msg=1, valid=0`, `frame_err` and `pkt_done` pulse, parser `valid_msg` stays 0.
- Count 3, lengths 0, 65 (>64), 1 → no output for the first two, `frame_err` for 65, single-byte message with `start_msg=end_msg=1` and `seq_num` = base+2.
- Seq 0xFFFF_FFFF_FFFF_FFFF, count 2 → second message tagged seq 0.
- New `pkt_sop` at payload byte 5 → terminator with `valid=0`, `frame_err`, new packet parsed correctly. `rst` pulse mid-payload → all outputs 0 and the trailing bytes ignored.
